// File: rtl/count_display_ctrl.sv
// count_display_ctrl: turns a binary photon count into four BCD digits for the
// seven-segment decoders. Loads are converted with a sequential double-dabble
// (16 iterations), saturated at 9999 with an overflow flag, leading zeros are
// flagged for blanking, and each displayed value is held for HOLD_CYCLES
// before the next one is taken. Loads arriving while busy are kept one deep,
// latest wins.
module count_display_ctrl #(
  parameter int unsigned HOLD_CYCLES = 5000000,
  parameter int unsigned HOLD_W      = 23
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] count_in,
  output logic        busy,
  output logic        pend,
  output logic        done,
  output logic [3:0]  dig0,
  output logic [3:0]  dig1,
  output logic [3:0]  dig2,
  output logic [3:0]  dig3,
  output logic [3:0]  blank,
  output logic        ovf
);

  typedef enum logic [1:0] {
    StIdle,
    StConvert,
    StHold
  } state_e;

  localparam logic [15:0]       MaxDisp   = 16'd9999;
  localparam logic [4:0]        NumIter   = 5'd16;
  localparam logic [HOLD_W-1:0] HoldStart = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HoldLast  = HOLD_W'(1);

  state_e            r_state;
  logic              r_pend;
  logic [15:0]       r_pend_val;
  logic [15:0]       r_bin;
  logic [15:0]       r_bcd;
  logic [4:0]        r_iter;
  logic [HOLD_W-1:0] r_hold;
  logic              r_ovf_nxt;
  logic              r_done;
  logic [3:0]        r_dig0;
  logic [3:0]        r_dig1;
  logic [3:0]        r_dig2;
  logic [3:0]        r_dig3;
  logic [3:0]        r_blank;
  logic              r_ovf;

  logic [15:0]       w_src;
  logic              w_sat;
  logic [15:0]       w_cap_val;
  logic [15:0]       w_bcd_adj;
  logic [3:0]        w_blank_nxt;

  // Capture source and saturation: a direct load always beats the pending value.
  always_comb begin
    w_src     = load ? count_in : r_pend_val;
    w_sat     = (w_src > MaxDisp);
    w_cap_val = w_sat ? MaxDisp : w_src;
  end

  // Double-dabble correction: add 3 to each BCD nibble that is 5 or more.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 4; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Leading-zero flags for the finished conversion; the ones digit is never blanked.
  always_comb begin
    w_blank_nxt    = 4'b0000;
    w_blank_nxt[3] = (r_bcd[15:12] == 4'd0);
    w_blank_nxt[2] = w_blank_nxt[3] & (r_bcd[11:8] == 4'd0);
    w_blank_nxt[1] = w_blank_nxt[2] & (r_bcd[7:4] == 4'd0);
  end

  // Sequencer FSM with pending buffer and registered display outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_pend     <= 1'b0;
      r_pend_val <= 16'd0;
      r_bin      <= 16'd0;
      r_bcd      <= 16'd0;
      r_iter     <= 5'd0;
      r_hold     <= '0;
      r_ovf_nxt  <= 1'b0;
      r_done     <= 1'b0;
      r_dig0     <= 4'd0;
      r_dig1     <= 4'd0;
      r_dig2     <= 4'd0;
      r_dig3     <= 4'd0;
      r_blank    <= 4'b1110;
      r_ovf      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (load || r_pend) begin
            r_pend    <= 1'b0;
            r_bin     <= w_cap_val;
            r_bcd     <= 16'd0;
            r_ovf_nxt <= w_sat;
            r_iter    <= NumIter;
            r_state   <= StConvert;
          end
        end

        StConvert: begin
          if (load) begin
            r_pend     <= 1'b1;
            r_pend_val <= count_in;
          end
          if (r_iter != 5'd0) begin
            {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
            r_iter         <= r_iter - 5'd1;
          end else begin
            // All 16 shifts done: publish the digits on this edge only.
            r_dig0  <= r_bcd[3:0];
            r_dig1  <= r_bcd[7:4];
            r_dig2  <= r_bcd[11:8];
            r_dig3  <= r_bcd[15:12];
            r_blank <= w_blank_nxt;
            r_ovf   <= r_ovf_nxt;
            r_done  <= 1'b1;
            if (HOLD_CYCLES == 0) begin
              r_state <= StIdle;
            end else begin
              r_hold  <= HoldStart;
              r_state <= StHold;
            end
          end
        end

        StHold: begin
          // A load on the exit edge is still buffered and taken from IDLE.
          if (load) begin
            r_pend     <= 1'b1;
            r_pend_val <= count_in;
          end
          r_hold <= r_hold - HoldLast;
          if (r_hold <= HoldLast) begin
            r_state <= StIdle;
          end
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy  = (r_state != StIdle);
  assign pend  = r_pend;
  assign done  = r_done;
  assign dig0  = r_dig0;
  assign dig1  = r_dig1;
  assign dig2  = r_dig2;
  assign dig3  = r_dig3;
  assign blank = r_blank;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_count_display_ctrl.sv
// Directed bench for count_display_ctrl with a short hold interval.
module tb_count_display_ctrl;

  localparam int unsigned HoldCycles = 4;

  logic        clk;
  logic        reset_n;
  logic        load;
  logic [15:0] count_in;
  logic        busy;
  logic        pend;
  logic        done;
  logic [3:0]  dig0;
  logic [3:0]  dig1;
  logic [3:0]  dig2;
  logic [3:0]  dig3;
  logic [3:0]  blank;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  count_display_ctrl #(
    .HOLD_CYCLES(HoldCycles),
    .HOLD_W     (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .count_in(count_in),
    .busy    (busy),
    .pend    (pend),
    .done    (done),
    .dig0    (dig0),
    .dig1    (dig1),
    .dig2    (dig2),
    .dig3    (dig3),
    .blank   (blank),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cnt;
    logic [15:0] bcd;    // expected {dig3,dig2,dig1,dig0}
    logic [3:0]  blank;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load     = 1'b1;
    count_in = v;
    tick();
    load     = 1'b0;
  endtask

  // Ticks until done is seen; returns the number of edges taken (max+1 on timeout).
  task automatic wait_done(input int max, output int n);
    n = 0;
    while (n <= max) begin
      tick();
      n++;
      if (done) break;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_disp(input string name, input logic [15:0] bcd, input logic [3:0] bl,
                          input logic ov);
    chk({name, "_dig"}, {16'd0, dig3, dig2, dig1, dig0}, {16'd0, bcd});
    chk({name, "_blank"}, {28'd0, blank}, {28'd0, bl});
    chk({name, "_ovf"}, {31'd0, ovf}, {31'd0, ov});
  endtask

  initial begin
    int n;
    int ndone;

    vecs[0] = '{16'd1234,  16'h1234, 4'b0000, 1'b0};
    vecs[1] = '{16'd7,     16'h0007, 4'b1110, 1'b0};
    vecs[2] = '{16'd0,     16'h0000, 4'b1110, 1'b0};
    vecs[3] = '{16'd40,    16'h0040, 4'b1100, 1'b0};
    vecs[4] = '{16'hFFFF,  16'h9999, 4'b0000, 1'b1};
    vecs[5] = '{16'd9999,  16'h9999, 4'b0000, 1'b0};
    vecs[6] = '{16'd10000, 16'h9999, 4'b0000, 1'b1};
    vecs[7] = '{16'd305,   16'h0305, 4'b1000, 1'b0};
    vecs[8] = '{16'd1000,  16'h1000, 4'b0000, 1'b0};
    vecs[9] = '{16'd9,     16'h0009, 4'b1110, 1'b0};

    reset_n  = 1'b0;
    load     = 1'b0;
    count_in = 16'd0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Reset state and quiet idle.
    chk_disp("reset", 16'h0000, 4'b1110, 1'b0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_pend", {31'd0, pend}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done || busy) ndone++;
    end
    chk("idle_quiet", ndone, 0);

    // Table: latency 17, outputs, single-cycle done, busy through hold.
    for (int i = 0; i < 10; i++) begin
      do_load(vecs[i].cnt);
      wait_done(30, n);
      chk($sformatf("v%0d_latency", i), n, 17);
      chk_disp($sformatf("v%0d", i), vecs[i].bcd, vecs[i].blank, vecs[i].ovf);
      tick();
      chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
      chk_disp($sformatf("v%0d_stable", i), vecs[i].bcd, vecs[i].blank, vecs[i].ovf);
      repeat (2) tick();
      chk($sformatf("v%0d_busy_hold", i), {31'd0, busy}, 32'd1);
      repeat (2) tick();
      chk($sformatf("v%0d_busy_end", i), {31'd0, busy}, 32'd0);
      wait_idle();
    end

    // Two loads during conversion: latest wins, 55 never shown.
    do_load(16'd1234);
    repeat (2) tick();
    do_load(16'd55);
    do_load(16'd66);
    chk("pend_set", {31'd0, pend}, 32'd1);
    wait_done(30, n);
    chk("pend_first_latency", n, 13);
    chk_disp("pend_first", 16'h1234, 4'b0000, 1'b0);
    wait_done(40, n);
    chk("pend_spacing", n, 17 + HoldCycles + 1);
    chk_disp("pend_second", 16'h0066, 4'b1100, 1'b0);
    chk("pend_clear", {31'd0, pend}, 32'd0);
    wait_idle();

    // Load on the HOLD->IDLE edge is buffered and taken next cycle.
    do_load(16'd500);
    wait_done(30, n);
    chk("edge_first_latency", n, 17);
    repeat (3) tick();
    do_load(16'd77);
    chk("edge_pend_set", {31'd0, pend}, 32'd1);
    chk("edge_idle", {31'd0, busy}, 32'd0);
    wait_done(40, n);
    chk("edge_latency", n, 18);
    chk_disp("edge_second", 16'h0077, 4'b1100, 1'b0);
    wait_idle();

    // Reset mid-conversion aborts without a done pulse.
    do_load(16'd4321);
    repeat (8) tick();
    #2 reset_n = 1'b0;
    #1;
    chk_disp("abort", 16'h0000, 4'b1110, 1'b0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    ndone = 0;
    repeat (2) begin
      tick();
      if (done) ndone++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    do_load(16'd12);
    wait_done(30, n);
    chk("after_abort_latency", n, 17);
    chk_disp("after_abort", 16'h0012, 4'b1100, 1'b0);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
